// File: rtl/bcd_serial_adder_pkg.sv
// Shared constants, FSM encoding and digit helpers for the digit-serial BCD adder.
package bcd_serial_adder_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
   localparam logic [DIGIT_W-1:0] BCD_ADJ = 4'd6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   function automatic logic bcd_bad(input logic [DIGIT_W-1:0] d);
      return d > BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_serial_adder_if.sv
// Digit-stream input and packed-result output handshakes of the serial BCD adder.
interface bcd_serial_adder_if
   import bcd_serial_adder_pkg::*;
#(
   parameter int DIGITS = 4
);
   logic                      start;
   logic                      dig_valid;
   logic                      dig_ready;
   logic [DIGIT_W-1:0]        a_dig;
   logic [DIGIT_W-1:0]        b_dig;
   logic [DIGIT_W*DIGITS-1:0] sum_bcd;
   logic                      cout;
   logic                      sum_valid;
   logic                      sum_ack;
   logic                      err;

   modport master (
      output start, dig_valid, a_dig, b_dig, sum_ack,
      input  dig_ready, sum_bcd, cout, sum_valid, err
   );

   modport slave (
      input  start, dig_valid, a_dig, b_dig, sum_ack,
      output dig_ready, sum_bcd, cout, sum_valid, err
   );
endinterface

// File: rtl/bcd_serial_adder_digit_add.sv
// One-digit BCD adder with decimal correction; also flags non-BCD operands.
module bcd_digit_add
   import bcd_serial_adder_pkg::*;
(
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               cin,
   output logic [DIGIT_W-1:0] s,
   output logic               cout,
   output logic               bad
);
   logic [DIGIT_W:0] t;

   always_comb begin
      t    = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
      cout = t > {1'b0, BCD_MAX};
      // Adding 6 modulo 16 is the same as taking the low nibble of t+6.
      s    = cout ? t[DIGIT_W-1:0] + BCD_ADJ : t[DIGIT_W-1:0];
      bad  = bcd_bad(a) | bcd_bad(b);
   end
endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder: LSD-first digit pairs in, packed sum held until acked.
module bcd_serial_adder
   import bcd_serial_adder_pkg::*;
#(
   parameter int DIGITS = 4
)(
   input  logic               clk,
   input  logic               rst,
   bcd_serial_adder_if.slave  bus
);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int SUM_W = DIGIT_W * DIGITS;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;
   logic               err_q, err_d;
   logic [SUM_W-1:0]   sum_q, sum_d;
   logic               clr;
   logic               xfer;
   logic [DIGIT_W-1:0] dig_sum;
   logic               dig_cout;
   logic               dig_bad;

   bcd_digit_add u_digit (
      .a    (bus.a_dig),
      .b    (bus.b_dig),
      .cin  (carry_q),
      .s    (dig_sum),
      .cout (dig_cout),
      .bad  (dig_bad)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      err_d   = err_q;
      clr     = 1'b0;
      xfer    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               clr     = 1'b1;
               idx_d   = '0;
               carry_d = 1'b0;
               cout_d  = 1'b0;
               err_d   = 1'b0;
               state_d = S_ADD;
            end
         end
         S_ADD: begin
            if (bus.dig_valid) begin
               xfer    = 1'b1;
               carry_d = dig_cout;
               if (dig_bad) err_d = 1'b1;
               if (idx_q == LAST_IDX) begin
                  cout_d  = dig_cout;
                  state_d = S_HOLD;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (bus.sum_ack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Each result slot only changes on a clear or on the transfer aimed at it.
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_slot
         assign sum_d[DIGIT_W*gi +: DIGIT_W] =
            clr                               ? '0      :
            (xfer && idx_q == IDX_W'(gi))     ? dig_sum :
                                                sum_q[DIGIT_W*gi +: DIGIT_W];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         err_q   <= err_d;
         sum_q   <= sum_d;
      end
   end

   assign bus.dig_ready = (state_q == S_ADD);
   assign bus.sum_valid = (state_q == S_HOLD);
   assign bus.sum_bcd   = sum_q;
   assign bus.cout      = cout_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder: decimal-integer model, one task per scenario.
module tb_bcd_serial_adder;
   localparam int DIGITS = 4;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        err;
      bit          chk_sum;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fails  = 0;
   exp_t sb[$];
   exp_t e;

   bcd_serial_adder_if #(.DIGITS(DIGITS)) bus ();

   bcd_serial_adder #(.DIGITS(DIGITS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic int bcd2int(input logic [15:0] x);
      int n = 0;
      for (int i = DIGITS - 1; i >= 0; i--) n = n * 10 + int'(x[4*i +: 4]);
      return n;
   endfunction

   function automatic logic [15:0] int2bcd(input int n);
      logic [15:0] r = '0;
      int m = n;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_op(input logic [15:0] a, input logic [15:0] b, input logic err_exp, input bit chk);
      exp_t x;
      int s = bcd2int(a) + bcd2int(b);
      x.sum     = int2bcd(s % 10000);
      x.cout    = (s >= 10000);
      x.err     = err_exp;
      x.chk_sum = chk;
      sb.push_back(x);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   // Drives all DIGITS pairs; pattern bit p gives dig_valid at step p (1 beyond plen).
   task automatic feed(input logic [15:0] a, input logic [15:0] b, input logic [15:0] pattern,
                       input int plen, input logic start_in_gap);
      int k = 0;
      int p = 0;
      logic v;
      while (k < DIGITS) begin
         v = (p < plen) ? pattern[p] : 1'b1;
         bus.dig_valid = v;
         bus.a_dig     = a[4*k +: 4];
         bus.b_dig     = b[4*k +: 4];
         bus.start     = v ? 1'b0 : start_in_gap;
         tick();
         if (v) k++;
         p++;
      end
      bus.dig_valid = 1'b0;
      bus.start     = 1'b0;
   endtask

   task automatic ack_result();
      bus.sum_ack = 1'b1;
      tick();
      bus.sum_ack = 1'b0;
   endtask

   task automatic test_reset();
      bus.start = 0; bus.dig_valid = 0; bus.a_dig = 0; bus.b_dig = 0; bus.sum_ack = 0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      n_checks++;
      if ({bus.sum_bcd, bus.cout, bus.sum_valid, bus.dig_ready, bus.err} !== 20'h0) begin
         n_fails++;
         $display("FAIL reset_outputs: got sum=%h cout=%b valid=%b ready=%b err=%b, want all 0",
                  bus.sum_bcd, bus.cout, bus.sum_valid, bus.dig_ready, bus.err);
      end
      $display("test_reset: outputs after reset checked");
   endtask

   task automatic test_basic();
      begin_op(16'h1234, 16'h5678, 1'b0, 1'b1);
      feed(16'h1234, 16'h5678, 16'h0, 0, 1'b0);
      e = sb.pop_front();
      n_checks++;
      if (bus.sum_valid !== 1'b1) begin
         n_fails++; $display("FAIL basic_latency: sum_valid=%b, want 1", bus.sum_valid);
      end
      n_checks++;
      if (bus.sum_bcd !== e.sum || bus.cout !== e.cout || bus.err !== e.err) begin
         n_fails++;
         $display("FAIL basic_result: got %h/%b/%b, want %h/%b/%b",
                  bus.sum_bcd, bus.cout, bus.err, e.sum, e.cout, e.err);
      end
      ack_result();
      n_checks++;
      if (bus.sum_valid !== 1'b0 || bus.dig_ready !== 1'b0) begin
         n_fails++;
         $display("FAIL basic_ack: valid=%b ready=%b, want 0/0", bus.sum_valid, bus.dig_ready);
      end
      $display("test_basic: 1234+5678 -> %h cout=%b", bus.sum_bcd, bus.cout);
   endtask

   task automatic test_carry();
      logic [15:0] av [2] = '{16'h9999, 16'h9999};
      logic [15:0] bv [2] = '{16'h0001, 16'h9999};
      for (int i = 0; i < 2; i++) begin
         begin_op(av[i], bv[i], 1'b0, 1'b1);
         feed(av[i], bv[i], 16'h0, 0, 1'b0);
         e = sb.pop_front();
         n_checks++;
         if (bus.sum_valid !== 1'b1 || bus.sum_bcd !== e.sum || bus.cout !== e.cout) begin
            n_fails++;
            $display("FAIL carry_%0d: got valid=%b %h/%b, want 1 %h/%b",
                     i, bus.sum_valid, bus.sum_bcd, bus.cout, e.sum, e.cout);
         end
         $display("test_carry: %h+%h -> %h cout=%b", av[i], bv[i], bus.sum_bcd, bus.cout);
         ack_result();
      end
   endtask

   task automatic test_err();
      begin_op(16'h12A4, 16'h5678, 1'b1, 1'b0);
      feed(16'h12A4, 16'h5678, 16'h0, 0, 1'b0);
      e = sb.pop_front();
      repeat (3) tick();
      n_checks++;
      if (bus.sum_valid !== 1'b1 || bus.err !== e.err) begin
         n_fails++;
         $display("FAIL err_hold: valid=%b err=%b, want 1/%b", bus.sum_valid, bus.err, e.err);
      end
      ack_result();
      n_checks++;
      if (bus.err !== 1'b1) begin
         n_fails++; $display("FAIL err_idle: err=%b, want 1 until next start", bus.err);
      end
      begin_op(16'h0000, 16'h0000, 1'b0, 1'b1);
      n_checks++;
      if (bus.err !== 1'b0 || bus.dig_ready !== 1'b1) begin
         n_fails++;
         $display("FAIL err_clear: err=%b ready=%b, want 0/1", bus.err, bus.dig_ready);
      end
      feed(16'h0000, 16'h0000, 16'h0, 0, 1'b0);
      e = sb.pop_front();
      n_checks++;
      if (bus.sum_bcd !== e.sum || bus.cout !== e.cout || bus.err !== e.err) begin
         n_fails++;
         $display("FAIL err_next_op: got %h/%b/%b, want %h/%b/%b",
                  bus.sum_bcd, bus.cout, bus.err, e.sum, e.cout, e.err);
      end
      ack_result();
      $display("test_err: bad digit flagged and cleared by next start");
   endtask

   task automatic test_gaps();
      begin_op(16'h1234, 16'h5678, 1'b0, 1'b1);
      feed(16'h1234, 16'h5678, 16'b1101001, 7, 1'b0);
      e = sb.pop_front();
      for (int c = 0; c < 5; c++) begin
         n_checks++;
         if (bus.sum_valid !== 1'b1 || bus.dig_ready !== 1'b0 ||
             bus.sum_bcd !== e.sum || bus.cout !== e.cout || bus.err !== e.err) begin
            n_fails++;
            $display("FAIL gaps_hold_%0d: valid=%b ready=%b %h/%b/%b, want 1 0 %h/%b/%b",
                     c, bus.sum_valid, bus.dig_ready, bus.sum_bcd, bus.cout, bus.err,
                     e.sum, e.cout, e.err);
         end
         tick();
      end
      ack_result();
      n_checks++;
      if (bus.sum_valid !== 1'b0 || bus.sum_bcd !== e.sum) begin
         n_fails++;
         $display("FAIL gaps_after_ack: valid=%b sum=%h, want 0 %h", bus.sum_valid, bus.sum_bcd, e.sum);
      end
      $display("test_gaps: gapped stream -> %h cout=%b", e.sum, e.cout);
   endtask

   task automatic test_midreset();
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      bus.dig_valid = 1'b1; bus.a_dig = 4'd7; bus.b_dig = 4'd8;
      tick(); tick();
      bus.dig_valid = 1'b0;
      rst = 1'b1; tick(); rst = 1'b0;
      n_checks++;
      if ({bus.sum_bcd, bus.cout, bus.sum_valid, bus.dig_ready, bus.err} !== 20'h0) begin
         n_fails++;
         $display("FAIL midreset_outputs: sum=%h cout=%b valid=%b ready=%b err=%b, want all 0",
                  bus.sum_bcd, bus.cout, bus.sum_valid, bus.dig_ready, bus.err);
      end
      tick();
      n_checks++;
      if (bus.dig_ready !== 1'b0) begin
         n_fails++; $display("FAIL midreset_idle: ready=%b, want 0", bus.dig_ready);
      end
      begin_op(16'h0005, 16'h0005, 1'b0, 1'b1);
      feed(16'h0005, 16'h0005, 16'h0, 0, 1'b0);
      e = sb.pop_front();
      n_checks++;
      if (bus.sum_bcd !== e.sum || bus.cout !== e.cout || bus.sum_valid !== 1'b1) begin
         n_fails++;
         $display("FAIL midreset_fresh: got %h/%b valid=%b, want %h/%b 1",
                  bus.sum_bcd, bus.cout, bus.sum_valid, e.sum, e.cout);
      end
      ack_result();
      $display("test_midreset: abort then 0005+0005 -> %h", e.sum);
   endtask

   task automatic test_start_ignored();
      begin_op(16'h4321, 16'h1111, 1'b0, 1'b1);
      feed(16'h4321, 16'h1111, 16'b110101, 6, 1'b1);
      e = sb.pop_front();
      n_checks++;
      if (bus.sum_valid !== 1'b1 || bus.sum_bcd !== e.sum || bus.cout !== e.cout) begin
         n_fails++;
         $display("FAIL start_in_add: got valid=%b %h/%b, want 1 %h/%b",
                  bus.sum_valid, bus.sum_bcd, bus.cout, e.sum, e.cout);
      end
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      n_checks++;
      if (bus.sum_valid !== 1'b1 || bus.sum_bcd !== e.sum) begin
         n_fails++;
         $display("FAIL start_in_hold: valid=%b sum=%h, want 1 %h", bus.sum_valid, bus.sum_bcd, e.sum);
      end
      bus.start = 1'b1; bus.sum_ack = 1'b1; tick();
      bus.start = 1'b0; bus.sum_ack = 1'b0;
      n_checks++;
      if (bus.sum_valid !== 1'b0 || bus.dig_ready !== 1'b0) begin
         n_fails++;
         $display("FAIL start_with_ack: valid=%b ready=%b, want 0/0", bus.sum_valid, bus.dig_ready);
      end
      tick();
      n_checks++;
      if (bus.dig_ready !== 1'b0) begin
         n_fails++; $display("FAIL start_with_ack_idle: ready=%b, want 0", bus.dig_ready);
      end
      $display("test_start_ignored: 4321+1111 -> %h, stray starts dropped", e.sum);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_err();
      test_gaps();
      test_midreset();
      test_start_ignored();
      n_checks++;
      if (sb.size() != 0) begin
         n_fails++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
